// File: rtl/dmem_arbiter.sv
// Two-port round-robin data-memory arbiter with a single-cycle response path.
// The grant and memory strobe are combinational from the requests and the
// priority pointer. The owner, error and read flags of each grant are
// registered so that the response returns exactly one cycle later.
module dmem_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // port 0: core load/store
   input  logic                  m0_req_i,
   input  logic                  m0_we_i,
   input  logic [DATA_W/8-1:0]   m0_be_i,
   input  logic [ADDR_W-1:0]     m0_addr_i,
   input  logic [DATA_W-1:0]     m0_wdata_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic [DATA_W-1:0]     m0_rdata_o,
   output logic                  m0_err_o,
   // port 1: debug/loader
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [DATA_W/8-1:0]   m1_be_i,
   input  logic [ADDR_W-1:0]     m1_addr_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_W-1:0]     m1_rdata_o,
   output logic                  m1_err_o,
   // memory side
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [DATA_W/8-1:0]   mem_be_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic [DATA_W-1:0]     mem_rdata_i
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = (BE_W > 1) ? $clog2(BE_W) : 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      (BE_W > 1) ? ~ADDR_W'((64'd1 << OFF_W) - 64'd1) : '1;
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

   // Pointer names the preferred port on contention (0 = m0, 1 = m1).
   logic ptr_q, ptr_d;
   // Response tracking for the grant made in the previous cycle.
   logic rsp_valid_q, rsp_valid_d;
   logic rsp_owner_q, rsp_owner_d;
   logic rsp_err_q,   rsp_err_d;
   logic rsp_rd_q,    rsp_rd_d;

   logic              win_valid;
   logic              win_sel;
   logic              win_we;
   logic              win_err;
   logic [BE_W-1:0]   win_be;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              rsp_live;

   // Arbitration, memory request drive and next-state for pointer/response.
   always_comb begin
      win_valid = 1'b0;
      win_sel   = 1'b0;
      if (!rst_i) begin
         if (m0_req_i && m1_req_i) begin
            win_valid = 1'b1;
            win_sel   = ptr_q;
         end else if (m0_req_i) begin
            win_valid = 1'b1;
            win_sel   = 1'b0;
         end else if (m1_req_i) begin
            win_valid = 1'b1;
            win_sel   = 1'b1;
         end
      end

      win_we    = win_sel ? m1_we_i    : m0_we_i;
      win_be    = win_sel ? m1_be_i    : m0_be_i;
      win_addr  = win_sel ? m1_addr_i  : m0_addr_i;
      win_wdata = win_sel ? m1_wdata_i : m0_wdata_i;
      win_err   = win_valid && (win_addr >= LIMIT);

      m0_gnt_o    = win_valid && !win_sel;
      m1_gnt_o    = win_valid &&  win_sel;

      // Out-of-range accesses are granted but never reach the memory.
      mem_en_o    = win_valid && !win_err;
      mem_we_o    = mem_en_o && win_we;
      mem_be_o    = win_be;
      mem_addr_o  = win_addr & ALIGN_MASK;
      mem_wdata_o = win_wdata;

      ptr_d       = win_valid ? !win_sel : ptr_q;
      rsp_valid_d = win_valid;
      rsp_owner_d = win_sel;
      rsp_err_d   = win_err;
      rsp_rd_d    = win_valid && !win_we && !win_err;
   end

   // Pointer and response registers; reset drops any pending response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rd_q    <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_owner_q <= rsp_owner_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rd_q    <= rsp_rd_d;
      end
   end

   // Route the response to its owner; rdata is zero unless it is a live read.
   always_comb begin
      rsp_live    = rsp_valid_q && !rst_i;
      m0_rvalid_o = rsp_live && !rsp_owner_q;
      m1_rvalid_o = rsp_live &&  rsp_owner_q;
      m0_err_o    = m0_rvalid_o && rsp_err_q;
      m1_err_o    = m1_rvalid_o && rsp_err_q;
      m0_rdata_o  = (m0_rvalid_o && rsp_rd_q) ? mem_rdata_i : '0;
      m1_rdata_o  = (m1_rvalid_o && rsp_rd_q) ? mem_rdata_i : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [3:0]  m0_be = '0, m1_be = '0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem [0:1023];

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
      .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
      .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
      .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
      .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // Memory model: byte-masked write, read data one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
         mem_rdata <= mem[mem_addr[11:2]];
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state: outputs quiet even with requests present.
      step();
      set_m0(1'b1, 1'b1, 4'hF, 32'h10, 32'h1);
      set_m1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      #1;
      chk1("rst_m0_gnt", m0_gnt, 1'b0);
      chk1("rst_m1_gnt", m1_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      step();
      chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
      chk32("rst_m0_rdata", m0_rdata, 32'h0);
      rst = 1'b0;
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step();

      // Single write then read.
      set_m0(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      #1;
      chk1("wr_m0_gnt", m0_gnt, 1'b1);
      chk1("wr_m1_gnt", m1_gnt, 1'b0);
      chk1("wr_mem_en", mem_en, 1'b1);
      chk1("wr_mem_we", mem_we, 1'b1);
      chk32("wr_mem_addr", mem_addr, 32'h10);
      chk32("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      step();
      set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      chk1("wr_m0_rvalid", m0_rvalid, 1'b1);
      chk1("wr_m0_err", m0_err, 1'b0);
      chk32("wr_m0_rdata", m0_rdata, 32'h0);
      chk1("wr_m1_rvalid", m1_rvalid, 1'b0);
      #1;
      chk1("rd_m0_gnt", m0_gnt, 1'b1);
      chk1("rd_mem_we", mem_we, 1'b0);
      step();
      chk1("rd_m0_rvalid", m0_rvalid, 1'b1);
      chk32("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);

      // Unaligned read is word-aligned on the memory side.
      set_m0(1'b1, 1'b0, 4'h0, 32'h13, 32'h0);
      #1;
      chk32("unal_mem_addr", mem_addr, 32'h10);
      step();
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk32("unal_m0_rdata", m0_rdata, 32'hDEADBEEF);
      step();
      chk1("idle_m0_rvalid", m0_rvalid, 1'b0);
      chk32("idle_m0_rdata", m0_rdata, 32'h0);

      // Byte write: preload, then merge one byte from m1, then read back.
      set_m0(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
      step();
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00);
      #1;
      chk1("bw_m1_gnt", m1_gnt, 1'b1);
      chk32("bw_mem_be", {28'h0, mem_be}, 32'h2);
      step();
      set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk1("bw_m1_rvalid", m1_rvalid, 1'b1);
      set_m0(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      step();
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk32("bw_m0_rdata", m0_rdata, 32'h1122AB44);

      // Out-of-range read and write: granted, no memory strobe, error response.
      set_m1(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
      #1;
      chk1("oor_m1_gnt", m1_gnt, 1'b1);
      chk1("oor_mem_en", mem_en, 1'b0);
      step();
      set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk1("oor_m1_rvalid", m1_rvalid, 1'b1);
      chk1("oor_m1_err", m1_err, 1'b1);
      chk32("oor_m1_rdata", m1_rdata, 32'h0);
      chk1("oor_m0_rvalid", m0_rvalid, 1'b0);
      set_m0(1'b1, 1'b1, 4'hF, 32'h1FFC, 32'h55);
      #1;
      chk1("oorw_m0_gnt", m0_gnt, 1'b1);
      chk1("oorw_mem_en", mem_en, 1'b0);
      chk1("oorw_mem_we", mem_we, 1'b0);
      step();
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk1("oorw_m0_err", m0_err, 1'b1);
      chk1("oorw_m1_err", m1_err, 1'b0);

      // Contention after reset: grants alternate m0, m1, m0, m1.
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      set_m1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("rr_m0_gnt", m0_gnt, (i % 2) == 0);
         chk1("rr_m1_gnt", m1_gnt, (i % 2) == 1);
         if (i > 0) begin
            chk1("rr_m0_rvalid", m0_rvalid, (i % 2) == 1);
            chk1("rr_m1_rvalid", m1_rvalid, (i % 2) == 0);
            chk32("rr_rdata", (i % 2) == 1 ? m0_rdata : m1_rdata,
                  (i % 2) == 1 ? 32'hDEADBEEF : 32'h1122AB44);
         end
         step();
      end
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk1("rr_last_m1_rvalid", m1_rvalid, 1'b1);
      chk1("rr_last_m0_rvalid", m0_rvalid, 1'b0);
      chk32("rr_last_m1_rdata", m1_rdata, 32'h1122AB44);
      chk32("rr_last_m0_rdata", m0_rdata, 32'h0);
      step();

      // Reset mid-op: grant m0 read, reset before its response.
      set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      #1;
      chk1("mid_m0_gnt", m0_gnt, 1'b1);
      step();
      rst = 1'b1;
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk1("mid_rst_m0_rvalid", m0_rvalid, 1'b0);
      chk32("mid_rst_m0_rdata", m0_rdata, 32'h0);
      step();
      rst = 1'b0;
      #1;
      chk1("mid_rel_m0_rvalid", m0_rvalid, 1'b0);
      set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      set_m1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      #1;
      chk1("mid_m0_first", m0_gnt, 1'b1);
      chk1("mid_m1_wait", m1_gnt, 1'b0);
      step();
      chk1("mid_m0_rvalid", m0_rvalid, 1'b1);
      chk32("mid_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk1("mid_m1_gnt_next", m1_gnt, 1'b1);
      set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte enables are DATA_W/8 wide.
REQ-003 SHALL have parameter MEM_BYTES, default 4096, size of the backing memory in bytes.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i input 1, the only clock, all state updates on its rising edge; rst_i input 1, synchronous active-high reset.
REQ-005 SHALL have ports m0_req_i / m1_req_i, input 1: request valid from port 0 (core load/store) / port 1 (debug/loader).
REQ-006 SHALL have ports mN_we_i, input 1: 1 = write, 0 = read.
REQ-007 SHALL have ports mN_be_i, input DATA_W/8: byte enables (writes only).
REQ-008 SHALL have ports mN_addr_i, input ADDR_W: byte address.
REQ-009 SHALL have ports mN_wdata_i, input DATA_W: write data.
REQ-010 SHALL have ports mN_gnt_o, output 1: request accepted this cycle.
REQ-011 SHALL have ports mN_rvalid_o, output 1: response for the previously granted request.
REQ-012 SHALL have ports mN_rdata_o, output DATA_W: read data, valid with rvalid.
REQ-013 SHALL have ports mN_err_o, output 1: out-of-range access, valid with rvalid.
REQ-014 SHALL have ports mem_en_o, output 1: memory access strobe.
REQ-015 SHALL have ports mem_we_o, output 1: memory write.
REQ-016 SHALL have ports mem_be_o, output DATA_W/8: memory byte enables.
REQ-017 SHALL have ports mem_addr_o, output ADDR_W: word-aligned memory address.
REQ-018 SHALL have ports mem_wdata_o, output DATA_W: memory write data.
REQ-019 SHALL have ports mem_rdata_i, input DATA_W: memory read data, valid 1 cycle after mem_en_o.

Function
REQ-020 SHALL grant at most one request per cycle; gnt is combinational from req and the priority pointer.
REQ-021 SHALL arbitrate round-robin, with a 1-bit pointer naming the preferred port.
- Only one requester -> it wins.
- Both requesting -> the pointer port wins.
- After any grant the pointer moves to the other port.
REQ-022 SHALL drive mem_en_o=1 in the grant cycle, with we/be/wdata copied from the winner and mem_addr_o = winner addr with the low log2(DATA_W/8) bits forced to 0.
REQ-023 SHALL force mem_en_o=0 and mem_we_o=0 for an out-of-range access (addr >= MEM_BYTES); the request is still granted.
REQ-024 SHALL register the owner id, err flag and valid flag in the grant cycle, and assert rvalid to that owner only, exactly 1 cycle after the grant, for reads and writes alike.
REQ-025 SHALL return rdata = mem_rdata_i for in-range reads, and 0 for writes or errors; err_o=1 only for an out-of-range access.
REQ-026 SHALL sustain back-to-back grants, giving throughput of 1 access per cycle; a grant in cycle N and a response for cycle N-1 coexist.
REQ-027 SHALL hold all mN_rdata_o at 0 when the corresponding rvalid is 0.
REQ-028 SHALL have a requester that keeps req high without gnt hold addr/we/be/wdata stable; the arbiter carries no queue.
REQ-029 SHALL treat req deasserted in the cycle after its rvalid as legal, with no response pending.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, clear the pointer to port 0 and clear the response valid/owner/err registers.
REQ-031 SHALL, during reset, drive all gnt_o, rvalid_o, err_o and mem_en_o, mem_we_o to 0, and all rdata_o to 0.
REQ-032 SHALL, on reset mid-transaction, drop the pending response (no rvalid after release), and give the first request after release the normal 1-cycle latency.

Verification
REQ-033 SHALL cover single write then read: m0 write addr 0x10, data 0xDEADBEEF, be 4'hF -> gnt same cycle, m0_rvalid next cycle with err 0; m0 read 0x10 -> rdata 0xDEADBEEF after 1 cycle.
REQ-034 SHALL cover contention: m0 and m1 both request reads continuously for 4 cycles after reset -> grants alternate m0, m1, m0, m1; each rvalid appears only on its owner's port 1 cycle later.
REQ-035 SHALL cover byte write: preload 0x11223344 at 0x20, m1 write be 4'b0010 data 0x0000AB00 -> read 0x20 returns 0x1122AB44.
REQ-036 SHALL cover out-of-range: m1 read addr 0x1000 with MEM_BYTES 4096 -> gnt 1, mem_en_o 0, next cycle m1_rvalid 1, m1_err 1, rdata 0.
REQ-037 SHALL cover unaligned address: m0 read 0x13 -> mem_addr_o 0x10.
REQ-038 SHALL cover reset mid-op: grant m0 read, assert rst_i the next edge -> no m0_rvalid; pointer back to 0, so a simultaneous m0/m1 request grants m0 first.
